// File: rtl/zeroriscy_dbus_pkg.sv
// Shared types and address map for the zero-riscy data-bus arbiter.
package zeroriscy_dbus_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    TGT_SRAM = 2'd0,
    TGT_CON  = 2'd1,
    TGT_NONE = 2'd2
  } tgt_e;

  localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;
  localparam int unsigned MEM_AW_DEF   = 16;
  localparam logic [31:0] CON_ADDR_DEF = 32'h9A10_0000;

  localparam logic [31:0] TOHOST0 = 32'h8000_1000;
  localparam logic [31:0] TOHOST1 = 32'h8000_3000;
  localparam logic [31:0] TOHOST2 = 32'h8017_FFFC;

  localparam logic [3:0] BE_FULL = 4'hF;

  // True when the byte address is one of the snooped tohost mailboxes.
  function automatic logic is_tohost_addr(input logic [31:0] addr);
    return (addr == TOHOST0) || (addr == TOHOST1) || (addr == TOHOST2);
  endfunction

endpackage

// File: rtl/zeroriscy_dbus_decode.sv
// Address decoder for the winning data-bus request: target select,
// SRAM word address and tohost-write detection. Purely combinational.
module zeroriscy_dbus_decode
  import zeroriscy_dbus_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
  parameter int unsigned MEM_AW   = MEM_AW_DEF,
  parameter logic [31:0] CON_ADDR = CON_ADDR_DEF
) (
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output tgt_e              tgt_o,
  output logic [MEM_AW-1:0] wordAddr_o,
  output logic              isTohost_o
);

  logic [32:0] addrExt;
  logic [32:0] baseExt;
  logic [32:0] limitExt;
  logic [31:0] offset;
  logic        inWindow;

  // Classify the address; the window compare uses 33 bits so a window ending at 4 GiB cannot wrap.
  always_comb begin
    addrExt    = {1'b0, addr_i};
    baseExt    = {1'b0, MEM_BASE};
    limitExt   = baseExt + (33'd4 << MEM_AW);
    inWindow   = (addrExt >= baseExt) && (addrExt < limitExt);
    offset     = addr_i - MEM_BASE;
    tgt_o      = TGT_NONE;
    wordAddr_o = '0;
    isTohost_o = 1'b0;
    if (inWindow) begin
      tgt_o      = TGT_SRAM;
      wordAddr_o = MEM_AW'(offset >> 2);
      isTohost_o = we_i && (be_i == BE_FULL) && (wdata_i != 32'h0) && is_tohost_addr(addr_i);
    end else if (addr_i == CON_ADDR) begin
      tgt_o = TGT_CON;
    end
  end

endmodule

// File: rtl/zeroriscy_dbus_arbiter.sv
// Data-bus arbiter between the zero-riscy LSU and a host loader/debug master.
// Routes the granted request to SRAM, the console byte port, or flags it
// unmapped, and snoops tohost writes.
// Build option: define ZRS_DBUS_RR_ARB_EN for round-robin arbitration;
// otherwise the core has fixed priority on conflicts.
module zeroriscy_dbus_arbiter
  import zeroriscy_dbus_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
  parameter int unsigned MEM_AW   = MEM_AW_DEF,
  parameter logic [31:0] CON_ADDR = CON_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [3:0]        core_be_i,
  input  logic [31:0]       core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  output logic              core_err_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [3:0]        host_be_i,
  input  logic [31:0]       host_addr_i,
  input  logic [31:0]       host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [31:0]       host_rdata_o,
  output logic              host_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              tohost_valid_o,
  output logic [31:0]       tohost_data_o,
  output logic              console_valid_o,
  output logic [7:0]        console_char_o
);

  logic              grantCore;
  logic              grantHost;
  logic              grantAny;

  logic              selWe;
  logic [3:0]        selBe;
  logic [31:0]       selAddr;
  logic [31:0]       selWdata;

  tgt_e              decTgt;
  logic [MEM_AW-1:0] decWordAddr;
  logic              decTohost;

  logic              valid_q,       valid_d;
  owner_e            owner_q,       owner_d;
  tgt_e              tgt_q,         tgt_d;
  logic              we_q,          we_d;
  logic              tohostPulse_q, tohostPulse_d;
  logic [31:0]       tohostData_q,  tohostData_d;
  logic              conPulse_q,    conPulse_d;
  logic [7:0]        conChar_q,     conChar_d;
  logic [31:0]       respData;

`ifdef ZRS_DBUS_RR_ARB_EN
  owner_e            prio_q, prio_d;

  // Arbitrate: a lone requester always wins; on a conflict the requester holding priority wins.
  always_comb begin
    grantCore = 1'b0;
    grantHost = 1'b0;
    if (!reset) begin
      if (core_req_i && host_req_i) begin
        if (prio_q == OWN_HOST) grantHost = 1'b1;
        else                    grantCore = 1'b1;
      end else if (core_req_i) begin
        grantCore = 1'b1;
      end else if (host_req_i) begin
        grantHost = 1'b1;
      end
    end
  end

  // Priority passes to whichever requester was not just granted.
  always_comb begin
    prio_d = prio_q;
    if (grantCore)      prio_d = OWN_HOST;
    else if (grantHost) prio_d = OWN_CORE;
  end

  // Round-robin priority register; the core starts out with priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= OWN_CORE;
    else       prio_q <= prio_d;
  end
`else
  // Arbitrate: a lone requester always wins; on a conflict the core always wins.
  always_comb begin
    grantCore = 1'b0;
    grantHost = 1'b0;
    if (!reset) begin
      if (core_req_i)      grantCore = 1'b1;
      else if (host_req_i) grantHost = 1'b1;
    end
  end
`endif

  // Steer the winning request onto the shared decoder and SRAM port.
  always_comb begin
    grantAny = grantCore || grantHost;
    selWe    = grantHost ? host_we_i    : core_we_i;
    selBe    = grantHost ? host_be_i    : core_be_i;
    selAddr  = grantHost ? host_addr_i  : core_addr_i;
    selWdata = grantHost ? host_wdata_i : core_wdata_i;
  end

  zeroriscy_dbus_decode #(
    .MEM_BASE (MEM_BASE),
    .MEM_AW   (MEM_AW),
    .CON_ADDR (CON_ADDR)
  ) u_decode (
    .addr_i     (selAddr),
    .we_i       (selWe),
    .be_i       (selBe),
    .wdata_i    (selWdata),
    .tgt_o      (decTgt),
    .wordAddr_o (decWordAddr),
    .isTohost_o (decTohost)
  );

  // Grant-cycle outputs: SRAM strobe only for SRAM targets, idle fields held at zero.
  always_comb begin
    core_gnt_o  = grantCore;
    host_gnt_o  = grantHost;
    mem_req_o   = grantAny && (decTgt == TGT_SRAM);
    mem_we_o    = mem_req_o && selWe;
    mem_be_o    = mem_req_o ? selBe       : 4'h0;
    mem_addr_o  = mem_req_o ? decWordAddr : '0;
    mem_wdata_o = mem_req_o ? selWdata    : 32'h0;
  end

  // Next state for the single outstanding response and the snoop side-channels.
  always_comb begin
    valid_d       = grantAny;
    owner_d       = grantHost ? OWN_HOST : OWN_CORE;
    tgt_d         = grantAny ? decTgt : TGT_NONE;
    we_d          = grantAny && selWe;
    tohostPulse_d = grantAny && decTohost;
    tohostData_d  = tohostData_q;
    conPulse_d    = grantAny && (decTgt == TGT_CON) && selWe;
    conChar_d     = conChar_q;
    if (tohostPulse_d) tohostData_d = selWdata;
    if (conPulse_d)    conChar_d    = selWdata[7:0];
  end

  // Response and snoop registers; reset discards any pending response and pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= 1'b0;
      owner_q       <= OWN_CORE;
      tgt_q         <= TGT_NONE;
      we_q          <= 1'b0;
      tohostPulse_q <= 1'b0;
      tohostData_q  <= 32'h0;
      conPulse_q    <= 1'b0;
      conChar_q     <= 8'h0;
    end else begin
      valid_q       <= valid_d;
      owner_q       <= owner_d;
      tgt_q         <= tgt_d;
      we_q          <= we_d;
      tohostPulse_q <= tohostPulse_d;
      tohostData_q  <= tohostData_d;
      conPulse_q    <= conPulse_d;
      conChar_q     <= conChar_d;
    end
  end

  // Route the response to its owner; only SRAM reads carry data back.
  always_comb begin
    respData        = (tgt_q == TGT_SRAM && !we_q) ? mem_rdata_i : 32'h0;
    core_rvalid_o   = valid_q && (owner_q == OWN_CORE);
    host_rvalid_o   = valid_q && (owner_q == OWN_HOST);
    core_rdata_o    = core_rvalid_o ? respData : 32'h0;
    host_rdata_o    = host_rvalid_o ? respData : 32'h0;
    core_err_o      = core_rvalid_o && (tgt_q == TGT_NONE);
    host_err_o      = host_rvalid_o && (tgt_q == TGT_NONE);
    tohost_valid_o  = tohostPulse_q;
    tohost_data_o   = tohostData_q;
    console_valid_o = conPulse_q;
    console_char_o  = conChar_q;
  end

endmodule

// File: tb/tb_zeroriscy_dbus_arbiter.sv
// Self-checking bench for zeroriscy_dbus_arbiter: vector table for single
// transactions, hand sequences for conflicts and mid-transaction reset.
module tb_zeroriscy_dbus_arbiter;

  typedef struct {
    bit          host;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          expMemReq;
    logic [15:0] expMemAddr;
    bit          expErr;
    logic [31:0] expRdata;
    bit          expTohost;
    logic [31:0] expTohostData;
    bit          expCon;
    logic [7:0]  expConChar;
  } vec_t;

  typedef struct {
    bit          host;
    bit          err;
    logic [31:0] rdata;
    bit          tohost;
    logic [31:0] tohostData;
    bit          con;
    logic [7:0]  conChar;
  } resp_t;

  localparam int NVEC = 17;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req_i, core_we_i, host_req_i, host_we_i;
  logic [3:0]  core_be_i, host_be_i;
  logic [31:0] core_addr_i, core_wdata_i, host_addr_i, host_wdata_i;
  logic        core_gnt_o, core_rvalid_o, core_err_o;
  logic        host_gnt_o, host_rvalid_o, host_err_o;
  logic [31:0] core_rdata_o, host_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        tohost_valid_o, console_valid_o;
  logic [31:0] tohost_data_o;
  logic [7:0]  console_char_o;

  vec_t        vecs [NVEC];
  resp_t       sbQ [$];
  int          assertCount = 0;
  int          failCount = 0;
  logic [31:0] heldTohost = 32'h0;
  logic [7:0]  heldCon = 8'h0;
  logic [31:0] sram [int];
  logic [31:0] memWord;

  zeroriscy_dbus_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .core_req_i      (core_req_i),
    .core_we_i       (core_we_i),
    .core_be_i       (core_be_i),
    .core_addr_i     (core_addr_i),
    .core_wdata_i    (core_wdata_i),
    .core_gnt_o      (core_gnt_o),
    .core_rvalid_o   (core_rvalid_o),
    .core_rdata_o    (core_rdata_o),
    .core_err_o      (core_err_o),
    .host_req_i      (host_req_i),
    .host_we_i       (host_we_i),
    .host_be_i       (host_be_i),
    .host_addr_i     (host_addr_i),
    .host_wdata_i    (host_wdata_i),
    .host_gnt_o      (host_gnt_o),
    .host_rvalid_o   (host_rvalid_o),
    .host_rdata_o    (host_rdata_o),
    .host_err_o      (host_err_o),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_rdata_i     (mem_rdata_i),
    .tohost_valid_o  (tohost_valid_o),
    .tohost_data_o   (tohost_data_o),
    .console_valid_o (console_valid_o),
    .console_char_o  (console_char_o)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Behavioural SRAM with byte-enable writes and one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req_o) begin
      memWord = sram.exists(int'(mem_addr_o)) ? sram[int'(mem_addr_o)] : 32'h0;
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) memWord[8*b +: 8] = mem_wdata_o[8*b +: 8];
        sram[int'(mem_addr_o)] = memWord;
      end else begin
        mem_rdata_i <= memWord;
      end
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    core_req_i = 1'b0; core_we_i = 1'b0; core_be_i = 4'h0; core_addr_i = 32'h0; core_wdata_i = 32'h0;
    host_req_i = 1'b0; host_we_i = 1'b0; host_be_i = 4'h0; host_addr_i = 32'h0; host_wdata_i = 32'h0;
  endtask

  task automatic applyStimulus(input vec_t v);
    idleInputs();
    if (v.host) begin
      host_req_i = 1'b1; host_we_i = v.we; host_be_i = v.be; host_addr_i = v.addr; host_wdata_i = v.wdata;
    end else begin
      core_req_i = 1'b1; core_we_i = v.we; core_be_i = v.be; core_addr_i = v.addr; core_wdata_i = v.wdata;
    end
  endtask

  task automatic checkGrant(input vec_t v);
    checkVal("core_gnt", 32'(core_gnt_o), 32'(!v.host));
    checkVal("host_gnt", 32'(host_gnt_o), 32'(v.host));
    checkVal("mem_req", 32'(mem_req_o), 32'(v.expMemReq));
    if (v.expMemReq) begin
      checkVal("mem_addr", 32'(mem_addr_o), 32'(v.expMemAddr));
      checkVal("mem_we", 32'(mem_we_o), 32'(v.we));
      checkVal("mem_be", 32'(mem_be_o), 32'(v.be));
      if (v.we) checkVal("mem_wdata", mem_wdata_o, v.wdata);
    end
    sbQ.push_back('{v.host, v.expErr, v.expRdata, v.expTohost, v.expTohostData, v.expCon, v.expConChar});
  endtask

  task automatic checkOutput();
    resp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkVal("core_rvalid", 32'(core_rvalid_o), 32'(!e.host));
      checkVal("host_rvalid", 32'(host_rvalid_o), 32'(e.host));
      checkVal("rdata", e.host ? host_rdata_o : core_rdata_o, e.rdata);
      checkVal("err", 32'(e.host ? host_err_o : core_err_o), 32'(e.err));
      checkVal("tohost_valid", 32'(tohost_valid_o), 32'(e.tohost));
      checkVal("console_valid", 32'(console_valid_o), 32'(e.con));
      heldTohost = e.tohostData;
      heldCon    = e.conChar;
    end else begin
      checkVal("idle_core_rvalid", 32'(core_rvalid_o), 32'h0);
      checkVal("idle_host_rvalid", 32'(host_rvalid_o), 32'h0);
      checkVal("idle_tohost_valid", 32'(tohost_valid_o), 32'h0);
      checkVal("idle_console_valid", 32'(console_valid_o), 32'h0);
    end
    checkVal("tohost_data", tohost_data_o, heldTohost);
    checkVal("console_char", 32'(console_char_o), 32'(heldCon));
  endtask

  task automatic checkAllZero(input string tag);
    $display("[TB] all-zero output check: %s", tag);
    checkVal("rst_core_gnt", 32'(core_gnt_o), 32'h0);
    checkVal("rst_host_gnt", 32'(host_gnt_o), 32'h0);
    checkVal("rst_core_rvalid", 32'(core_rvalid_o), 32'h0);
    checkVal("rst_host_rvalid", 32'(host_rvalid_o), 32'h0);
    checkVal("rst_core_rdata", core_rdata_o, 32'h0);
    checkVal("rst_host_rdata", host_rdata_o, 32'h0);
    checkVal("rst_core_err", 32'(core_err_o), 32'h0);
    checkVal("rst_host_err", 32'(host_err_o), 32'h0);
    checkVal("rst_mem_req", 32'(mem_req_o), 32'h0);
    checkVal("rst_mem_we", 32'(mem_we_o), 32'h0);
    checkVal("rst_mem_be", 32'(mem_be_o), 32'h0);
    checkVal("rst_mem_addr", 32'(mem_addr_o), 32'h0);
    checkVal("rst_mem_wdata", mem_wdata_o, 32'h0);
    checkVal("rst_tohost_valid", 32'(tohost_valid_o), 32'h0);
    checkVal("rst_tohost_data", tohost_data_o, 32'h0);
    checkVal("rst_console_valid", 32'(console_valid_o), 32'h0);
    checkVal("rst_console_char", 32'(console_char_o), 32'h0);
  endtask

  initial begin
    vec_t  v;
    bit    expHost;
    //          host we   be    addr          wdata         mreq  maddr    err   rdata         th    thdata        con   char
    vecs[0]  = '{1'b0, 1'b1, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF, 1'b1, 16'h0040, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 4'hF, 32'h8000_0100, 32'h0,         1'b1, 16'h0040, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 4'hF, 32'h8000_1000, 32'h1,         1'b1, 16'h0400, 1'b0, 32'h0,         1'b1, 32'h1, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 4'hF, 32'h8000_1000, 32'h0,         1'b1, 16'h0400, 1'b0, 32'h0,         1'b0, 32'h1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 32'h8000_1000, 32'h0,         1'b1, 16'h0400, 1'b0, 32'h0,         1'b0, 32'h1, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b1, 4'h1, 32'h9A10_0000, 32'h41,        1'b0, 16'h0000, 1'b0, 32'h0,         1'b0, 32'h1, 1'b1, 8'h41};
    vecs[6]  = '{1'b1, 1'b0, 4'hF, 32'h9A10_0000, 32'h0,         1'b0, 16'h0000, 1'b0, 32'h0,         1'b0, 32'h1, 1'b0, 8'h41};
    vecs[7]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0000, 32'h0,         1'b0, 16'h0000, 1'b1, 32'h0,         1'b0, 32'h1, 1'b0, 8'h41};
    vecs[8]  = '{1'b1, 1'b1, 4'hF, 32'h8000_3000, 32'h5,         1'b1, 16'h0C00, 1'b0, 32'h0,         1'b1, 32'h5, 1'b0, 8'h41};
    vecs[9]  = '{1'b1, 1'b1, 4'h3, 32'h8000_3000, 32'h7,         1'b1, 16'h0C00, 1'b0, 32'h0,         1'b0, 32'h5, 1'b0, 8'h41};
    vecs[10] = '{1'b1, 1'b0, 4'hF, 32'h8000_3000, 32'h0,         1'b1, 16'h0C00, 1'b0, 32'h7,         1'b0, 32'h5, 1'b0, 8'h41};
    vecs[11] = '{1'b0, 1'b1, 4'hF, 32'h8003_FFFC, 32'h1234_5678, 1'b1, 16'hFFFF, 1'b0, 32'h0,         1'b0, 32'h5, 1'b0, 8'h41};
    vecs[12] = '{1'b0, 1'b0, 4'hF, 32'h8004_0000, 32'h0,         1'b0, 16'h0000, 1'b1, 32'h0,         1'b0, 32'h5, 1'b0, 8'h41};
    vecs[13] = '{1'b0, 1'b0, 4'hF, 32'h8003_FFFC, 32'h0,         1'b1, 16'hFFFF, 1'b0, 32'h1234_5678, 1'b0, 32'h5, 1'b0, 8'h41};
    vecs[14] = '{1'b1, 1'b0, 4'hF, 32'h7FFF_FFFC, 32'h0,         1'b0, 16'h0000, 1'b1, 32'h0,         1'b0, 32'h5, 1'b0, 8'h41};
    vecs[15] = '{1'b1, 1'b1, 4'h1, 32'h9A10_0001, 32'hAA,        1'b0, 16'h0000, 1'b1, 32'h0,         1'b0, 32'h5, 1'b0, 8'h41};
    vecs[16] = '{1'b0, 1'b0, 4'hF, 32'h8000_0100, 32'h0,         1'b1, 16'h0040, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h5, 1'b0, 8'h41};

    idleInputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(vecs[0]);
    host_req_i = 1'b1; host_addr_i = 32'h8000_3000;
    #1 checkAllZero("initial reset with requests pending");

    @(negedge clk);
    idleInputs();
    reset = 1'b0;
    #1 checkOutput();

    $display("[TB] vector table: %0d single-requester transactions", NVEC);
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      checkOutput();
      applyStimulus(vecs[i]);
      #1 checkGrant(vecs[i]);
    end
    @(negedge clk); checkOutput(); idleInputs();
    @(negedge clk); checkOutput();

    // Fresh reset so arbitration starts from its reset priority.
    reset = 1'b1;
    #1 checkAllZero("reset before conflict sequence");
    @(negedge clk);
    reset = 1'b0;
    heldTohost = 32'h0;
    heldCon    = 8'h0;

    $display("[TB] conflict sequence: both requesters for 4 cycles");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput();
      core_req_i = 1'b1; core_we_i = 1'b0; core_be_i = 4'hF; core_addr_i = 32'h8000_0100; core_wdata_i = 32'h0;
      host_req_i = 1'b1; host_we_i = 1'b0; host_be_i = 4'hF; host_addr_i = 32'h8000_3000; host_wdata_i = 32'h0;
`ifdef ZRS_DBUS_RR_ARB_EN
      expHost = (k % 2) == 1;
`else
      expHost = 1'b0;
`endif
      #1;
      checkVal("conflict_core_gnt", 32'(core_gnt_o), 32'(!expHost));
      checkVal("conflict_host_gnt", 32'(host_gnt_o), 32'(expHost));
      sbQ.push_back('{expHost, 1'b0, expHost ? 32'h7 : 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 8'h00});
    end
    @(negedge clk); checkOutput(); idleInputs();
    @(negedge clk); checkOutput();

    $display("[TB] reset during a granted tohost write");
    v = '{1'b0, 1'b1, 4'hF, 32'h8000_1000, 32'h3, 1'b1, 16'h0400, 1'b0, 32'h0, 1'b1, 32'h3, 1'b0, 8'h00};
    applyStimulus(v);
    #1;
    checkVal("pre_reset_core_gnt", 32'(core_gnt_o), 32'h1);
    checkVal("pre_reset_mem_req", 32'(mem_req_o), 32'h1);
    #2 reset = 1'b1;
    #1 checkAllZero("reset raised inside grant cycle");
    @(negedge clk);
    checkAllZero("reset held across the response edge");
    idleInputs();
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput();

    @(negedge clk);
    checkOutput();
    v.wdata = 32'h2;
    v.expTohostData = 32'h2;
    applyStimulus(v);
    #1 checkGrant(v);
    @(negedge clk); checkOutput(); idleInputs();
    @(negedge clk); checkOutput();

    if (sbQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbQ.size());
    end
    assertCount++;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
